// File: rtl/io_peripheral.sv
// Device-side end of the processor byte I/O port: host valid/ready <-> four-phase req/ack, FIFO buffered both ways.
// Latency: host push -> procInDataReady 2 edges; procOutDataReady -> procOutACK/sinkValid 1 edge.
// Backpressure: srcReady low when TX FIFO full; procOutACK withheld while RX FIFO full.

module io_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdat_i,
    output logic [W-1:0]  rdat_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdat_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    // Storage is cleared on reset so the fall-through head reads 0 when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdat_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module io_peripheral #(
    parameter int dataWidth = 8,
    parameter int fifoDepth = 4,
    parameter int cntWidth  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [dataWidth-1:0] srcData,
    input  logic                 srcValid,
    output logic                 srcReady,
    output logic [dataWidth-1:0] sinkData,
    output logic                 sinkValid,
    input  logic                 sinkPop,
    output logic [dataWidth-1:0] procIn,
    output logic                 procInDataReady,
    input  logic                 procInACK,
    input  logic [dataWidth-1:0] procOut,
    input  logic                 procOutDataReady,
    output logic                 procOutACK,
    output logic [cntWidth-1:0]  txCount,
    output logic [cntWidth-1:0]  rxCount
);
    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_REQ = 2'd1, TX_WAIT = 2'd2} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_ACK = 2'd1} rx_state_e;

    tx_state_e              tx_state_q, tx_state_d;
    rx_state_e              rx_state_q, rx_state_d;
    logic [dataWidth-1:0]   proc_in_q, proc_in_d;
    logic                   in_rdy_q, in_rdy_d;
    logic                   out_ack_q, out_ack_d;

    logic                   tx_pop;
    logic [dataWidth-1:0]   tx_head;
    logic                   tx_full, tx_empty;
    logic                   rx_push;
    logic                   rx_full, rx_empty;

    io_fifo #(.W(dataWidth), .DEPTH(fifoDepth), .CW(cntWidth)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (srcValid),
        .pop_i   (tx_pop),
        .wdat_i  (srcData),
        .rdat_o  (tx_head),
        .count_o (txCount),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    io_fifo #(.W(dataWidth), .DEPTH(fifoDepth), .CW(cntWidth)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (rx_push),
        .pop_i   (sinkPop),
        .wdat_i  (procOut),
        .rdat_o  (sinkData),
        .count_o (rxCount),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign srcReady        = !tx_full;
    assign sinkValid       = !rx_empty;
    assign procIn          = proc_in_q;
    assign procInDataReady = in_rdy_q;
    assign procOutACK      = out_ack_q;

    // The TX head is popped only on ACK, so a byte is never lost if the handshake stalls.
    always_comb begin
        tx_state_d = tx_state_q;
        proc_in_d  = proc_in_q;
        in_rdy_d   = in_rdy_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    proc_in_d  = tx_head;
                    in_rdy_d   = 1'b1;
                    tx_state_d = TX_REQ;
                end
            end
            TX_REQ: begin
                if (procInACK) begin
                    in_rdy_d   = 1'b0;
                    tx_pop     = 1'b1;
                    tx_state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!procInACK) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: begin
                in_rdy_d   = 1'b0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // rx_full is the pre-edge count, so a same-cycle pop frees space only for the next edge.
    always_comb begin
        rx_state_d = rx_state_q;
        out_ack_d  = out_ack_q;
        rx_push    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (procOutDataReady && !rx_full) begin
                    rx_push    = 1'b1;
                    out_ack_d  = 1'b1;
                    rx_state_d = RX_ACK;
                end
            end
            RX_ACK: begin
                if (!procOutDataReady) begin
                    out_ack_d  = 1'b0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                out_ack_d  = 1'b0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_IDLE;
            proc_in_q  <= '0;
            in_rdy_q   <= 1'b0;
            out_ack_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            proc_in_q  <= proc_in_d;
            in_rdy_q   <= in_rdy_d;
            out_ack_q  <= out_ack_d;
        end
    end
endmodule

// File: tb/tb_io_peripheral.sv
// Directed bench for io_peripheral: reset values, TX/RX handshakes, full/stall corners, concurrent stream, mid-op reset.
module tb_io_peripheral;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int NRND  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] srcData;
    logic          srcValid;
    logic          srcReady;
    logic [DW-1:0] sinkData;
    logic          sinkValid;
    logic          sinkPop;
    logic [DW-1:0] procIn;
    logic          procInDataReady;
    logic          procInACK;
    logic [DW-1:0] procOut;
    logic          procOutDataReady;
    logic          procOutACK;
    logic [CW-1:0] txCount;
    logic [CW-1:0] rxCount;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] txb [NRND];
    logic [DW-1:0] rxb [NRND];

    always #5 clk = ~clk;

    io_peripheral #(.dataWidth(DW), .fifoDepth(DEPTH), .cntWidth(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .srcData          (srcData),
        .srcValid         (srcValid),
        .srcReady         (srcReady),
        .sinkData         (sinkData),
        .sinkValid        (sinkValid),
        .sinkPop          (sinkPop),
        .procIn           (procIn),
        .procInDataReady  (procInDataReady),
        .procInACK        (procInACK),
        .procOut          (procOut),
        .procOutDataReady (procOutDataReady),
        .procOutACK       (procOutACK),
        .txCount          (txCount),
        .rxCount          (rxCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_procIn"}, procIn, 0);
        chk({tag, "_inRdy"}, procInDataReady, 0);
        chk({tag, "_outAck"}, procOutACK, 0);
        chk({tag, "_srcReady"}, srcReady, 1);
        chk({tag, "_sinkValid"}, sinkValid, 0);
        chk({tag, "_txCount"}, txCount, 0);
        chk({tag, "_rxCount"}, rxCount, 0);
        chk({tag, "_sinkData"}, sinkData, 0);
    endtask

    task automatic tx_accept(input logic [DW-1:0] exp, input string tag);
        int g = 0;
        while (!procInDataReady && g < 20) begin
            tick();
            g++;
        end
        chk({tag, "_rdy"}, procInDataReady, 1);
        chk({tag, "_dat"}, procIn, exp);
        procInACK = 1'b1;
        tick();
        chk({tag, "_drop"}, procInDataReady, 0);
        procInACK = 1'b0;
        tick();
    endtask

    task automatic rx_send(input logic [DW-1:0] b, input string tag);
        int g = 0;
        procOut          = b;
        procOutDataReady = 1'b1;
        while (!procOutACK && g < 20) begin
            tick();
            g++;
        end
        chk({tag, "_ack"}, procOutACK, 1);
        procOutDataReady = 1'b0;
        tick();
        chk({tag, "_ackdrop"}, procOutACK, 0);
    endtask

    task automatic rx_pop(input logic [DW-1:0] exp, input string tag);
        chk({tag, "_vld"}, sinkValid, 1);
        chk({tag, "_dat"}, sinkData, exp);
        sinkPop = 1'b1;
        tick();
        sinkPop = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx_idx, tx_got, rx_sent, rx_got;
        int tx_err, rx_err, tmo;
        int g1, g2, g3, g4;
        logic accepted;

        reset = 1'b0;
        srcData = '0; srcValid = 1'b0; sinkPop = 1'b0;
        procInACK = 1'b0; procOut = '0; procOutDataReady = 1'b0;
        repeat (2) tick();
        chk_reset_state("rst0");
        reset = 1'b1;
        tick();

        // Single TX byte with exact edge timing
        srcData = 8'hA5; srcValid = 1'b1;
        tick();
        srcValid = 1'b0;
        chk("tx1_cnt_after_push", txCount, 1);
        chk("tx1_rdy_not_yet", procInDataReady, 0);
        tick();
        chk("tx1_rdy", procInDataReady, 1);
        chk("tx1_dat", procIn, 8'hA5);
        procInACK = 1'b1;
        tick();
        chk("tx1_rdy_drop", procInDataReady, 0);
        chk("tx1_cnt_zero", txCount, 0);
        tick();
        chk("tx1_rdy_hold_low", procInDataReady, 0);
        procInACK = 1'b0;
        tick();
        chk("tx1_idle", procInDataReady, 0);

        // TX full, dropped push, drain and wrap
        for (int i = 1; i <= 4; i++) begin
            srcData = DW'(i); srcValid = 1'b1;
            tick();
        end
        chk("txf_cnt4", txCount, 4);
        chk("txf_srcReady0", srcReady, 0);
        srcData = 8'h05;
        tick();
        srcValid = 1'b0;
        chk("txf_drop_cnt", txCount, 4);
        tx_accept(8'h01, "txf_b1");
        tx_accept(8'h02, "txf_b2");
        tx_accept(8'h03, "txf_b3");
        tx_accept(8'h04, "txf_b4");
        chk("txf_drained", txCount, 0);
        srcData = 8'h06; srcValid = 1'b1;
        tick();
        srcData = 8'h07;
        tick();
        srcValid = 1'b0;
        tx_accept(8'h06, "txw_b6");
        tx_accept(8'h07, "txw_b7");
        tick();
        chk("txw_no_extra", procInDataReady, 0);

        // Single RX byte
        procOut = 8'h3C; procOutDataReady = 1'b1;
        tick();
        chk("rx1_ack", procOutACK, 1);
        chk("rx1_dat", sinkData, 8'h3C);
        chk("rx1_vld", sinkValid, 1);
        chk("rx1_cnt", rxCount, 1);
        tick();
        chk("rx1_ack_hold", procOutACK, 1);
        chk("rx1_no_dup", rxCount, 1);
        procOutDataReady = 1'b0;
        tick();
        chk("rx1_ack_drop", procOutACK, 0);
        sinkPop = 1'b1;
        tick();
        chk("rx1_pop_cnt", rxCount, 0);
        tick();
        sinkPop = 1'b0;
        chk("rx1_pop_empty_cnt", rxCount, 0);
        chk("rx1_pop_empty_vld", sinkValid, 0);

        // RX full stall, release by pop
        rx_send(8'h11, "rxf_s1");
        rx_send(8'h22, "rxf_s2");
        rx_send(8'h33, "rxf_s3");
        rx_send(8'h44, "rxf_s4");
        chk("rxf_cnt4", rxCount, 4);
        procOut = 8'h99; procOutDataReady = 1'b1;
        tick();
        tick();
        chk("rxf_stall_ack", procOutACK, 0);
        chk("rxf_stall_cnt", rxCount, 4);
        chk("rxf_head", sinkData, 8'h11);
        sinkPop = 1'b1;
        tick();
        sinkPop = 1'b0;
        chk("rxf_pop_cnt", rxCount, 3);
        chk("rxf_pop_noack", procOutACK, 0);
        tick();
        chk("rxf_capture_ack", procOutACK, 1);
        chk("rxf_capture_cnt", rxCount, 4);
        procOutDataReady = 1'b0;
        tick();
        rx_pop(8'h22, "rxf_p2");
        rx_pop(8'h33, "rxf_p3");
        rx_pop(8'h44, "rxf_p4");
        rx_pop(8'h99, "rxf_p9");
        chk("rxf_empty", sinkValid, 0);

        // Concurrent traffic
        for (int i = 0; i < NRND; i++) begin
            txb[i] = DW'($urandom_range(0, 255));
            rxb[i] = DW'($urandom_range(0, 255));
        end
        tx_idx = 0; tx_got = 0; rx_sent = 0; rx_got = 0;
        tx_err = 0; rx_err = 0; tmo = 0;
        g1 = 0; g2 = 0; g3 = 0; g4 = 0;
        fork
            begin
                while (tx_idx < NRND && g1 < 3000) begin
                    srcData  = txb[tx_idx];
                    srcValid = 1'b1;
                    accepted = srcReady;
                    tick();
                    g1++;
                    if (accepted) tx_idx++;
                end
                srcValid = 1'b0;
                if (g1 >= 3000) tmo++;
            end
            begin
                while (tx_got < NRND && g2 < 3000) begin
                    if (procInDataReady) begin
                        if (procIn !== txb[tx_got]) tx_err++;
                        tx_got++;
                        procInACK = 1'b1;
                        tick();
                        if (procInDataReady) tx_err++;
                        procInACK = 1'b0;
                        g2++;
                    end
                    tick();
                    g2++;
                end
                if (g2 >= 3000) tmo++;
            end
            begin
                while (rx_sent < NRND && g3 < 3000) begin
                    procOut          = rxb[rx_sent];
                    procOutDataReady = 1'b1;
                    while (!procOutACK && g3 < 3000) begin
                        tick();
                        g3++;
                    end
                    procOutDataReady = 1'b0;
                    rx_sent++;
                    while (procOutACK && g3 < 3000) begin
                        tick();
                        g3++;
                    end
                end
                if (g3 >= 3000) tmo++;
            end
            begin
                while (rx_got < NRND && g4 < 3000) begin
                    if (sinkValid) begin
                        if (sinkData !== rxb[rx_got]) rx_err++;
                        rx_got++;
                        sinkPop = 1'b1;
                    end else begin
                        sinkPop = 1'b0;
                    end
                    tick();
                    g4++;
                end
                sinkPop = 1'b0;
                if (g4 >= 3000) tmo++;
            end
        join
        chk("cc_timeout", tmo, 0);
        chk("cc_tx_count", tx_got, NRND);
        chk("cc_tx_err", tx_err, 0);
        chk("cc_rx_count", rx_got, NRND);
        chk("cc_rx_err", rx_err, 0);
        tick();
        chk("cc_tx_empty", txCount, 0);
        chk("cc_rx_empty", rxCount, 0);

        // Reset while TX_REQ is outstanding and RX holds a byte
        rx_send(8'h77, "mr_rx");
        chk("mr_rx_cnt", rxCount, 1);
        srcData = 8'h5A; srcValid = 1'b1;
        tick();
        srcData = 8'h5B;
        tick();
        srcValid = 1'b0;
        chk("mr_rdy_before", procInDataReady, 1);
        chk("mr_cnt_before", txCount, 2);
        reset = 1'b0;
        #1;
        chk_reset_state("mr");
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("mr_rdy_after", procInDataReady, 0);
        chk("mr_cnt_after", txCount, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
